// File: rtl/clk_cfg_seq.sv
// Clock-configuration sequencer: parks the clock manager on 8 MHz, applies a new
// CLKMUX1/ROSC/divider setting, waits for it to settle, then unparks.
module clk_cfg_seq #(
  parameter int unsigned PARK_CYC   = 16,
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic       clk_mux1,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_sel_xclk,
  input  logic [1:0] req_sel_rosc,
  input  logic [1:0] req_clk_div,
  input  logic       xclk_fail,
  output logic       sel_n_8mhz,
  output logic       sel_xclk,
  output logic [1:0] sel_rosc,
  output logic [1:0] clk_div,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, PARK, APPLY, SETTLE, UNPARK} state_t;

  typedef struct packed {
    logic       xclk;
    logic [1:0] rosc;
    logic [1:0] div;
  } cfg_t;

  localparam cfg_t       RST_CFG     = '{xclk: 1'b0, rosc: 2'b11, div: 2'b00};
  localparam logic [7:0] PARK_LOAD   = 8'(PARK_CYC - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  cfg_t       pend_q, pend_d;
  cfg_t       cur_q, cur_d;
  logic       park_n_q, park_n_d;
  logic       abort_q, abort_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  cfg_t req_cfg;
  logic fallback;
  logic accept;
  logic req_bad;
  logic req_same;

  assign req_cfg  = '{xclk: req_sel_xclk, rosc: req_sel_rosc, div: req_clk_div};
  // Losing xclk while running on it outranks any incoming request.
  assign fallback = (state_q == IDLE) && cur_q.xclk && xclk_fail;
  assign req_ready = (state_q == IDLE) && !fallback;
  assign accept   = req_valid && req_ready;
  assign req_bad  = req_cfg.xclk && xclk_fail;
  assign req_same = (req_cfg == cur_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_mux1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= RST_CFG;
      cur_q    <= RST_CFG;
      park_n_q <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      cur_q    <= cur_d;
      park_n_q <= park_n_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fallback || (accept && !req_bad && !req_same)) state_d = PARK;
      PARK:    if (cnt_q == '0) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE: begin
        if (xclk_fail && cur_q.xclk) state_d = APPLY;
        else if (cnt_q == '0)        state_d = UNPARK;
      end
      UNPARK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    cur_d    = cur_q;
    park_n_d = park_n_q;
    abort_d  = abort_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fallback) begin
          pend_d   = '{xclk: 1'b0, rosc: cur_q.rosc, div: cur_q.div};
          abort_d  = 1'b1;
          park_n_d = 1'b0;
          cnt_d    = PARK_LOAD;
        end else if (accept) begin
          pend_d = req_cfg;
          if (req_bad) begin
            err_d = 1'b1;
          end else if (req_same) begin
            done_d = 1'b1;
          end else begin
            abort_d  = 1'b0;
            park_n_d = 1'b0;
            cnt_d    = PARK_LOAD;
          end
        end
      end
      PARK: if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
      APPLY: begin
        cur_d = pend_q;
        cnt_d = SETTLE_LOAD;
      end
      SETTLE: begin
        // Switched onto an xclk that has since vanished: retarget and re-settle.
        if (xclk_fail && cur_q.xclk) begin
          pend_d  = '{xclk: 1'b0, rosc: cur_q.rosc, div: cur_q.div};
          abort_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      UNPARK: begin
        park_n_d = 1'b1;
        done_d   = !abort_q;
        err_d    = abort_q;
        abort_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign sel_n_8mhz = park_n_q;
  assign sel_xclk   = cur_q.xclk;
  assign sel_rosc   = cur_q.rosc;
  assign clk_div    = cur_q.div;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Directed bench for clk_cfg_seq with default timing (16 park, 64 settle cycles).
module tb_clk_cfg_seq;

  logic       clk_mux1 = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_sel_xclk = 1'b0;
  logic [1:0] req_sel_rosc = 2'b00;
  logic [1:0] req_clk_div = 2'b00;
  logic       xclk_fail = 1'b0;
  logic       req_ready, sel_n_8mhz, sel_xclk, busy, done, err;
  logic [1:0] sel_rosc, clk_div;

  int total = 0;
  int bad   = 0;

  clk_cfg_seq dut (
    .clk_mux1     (clk_mux1),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel_xclk (req_sel_xclk),
    .req_sel_rosc (req_sel_rosc),
    .req_clk_div  (req_clk_div),
    .xclk_fail    (xclk_fail),
    .sel_n_8mhz   (sel_n_8mhz),
    .sel_xclk     (sel_xclk),
    .sel_rosc     (sel_rosc),
    .clk_div      (clk_div),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk_mux1 = ~clk_mux1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a request for one rising edge; returns at the following falling edge.
  task automatic send(input logic x, input logic [1:0] r, input logic [1:0] d);
    req_sel_xclk = x;
    req_sel_rosc = r;
    req_clk_div  = d;
    req_valid    = 1'b1;
    @(negedge clk_mux1);
    req_valid    = 1'b0;
  endtask

  // Cycles from the accepting edge until done or err shows, bounded.
  task automatic wait_end(input int limit, output int n);
    n = 0;
    while (!(done || err) && n < limit) begin
      @(negedge clk_mux1);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int chg;
    int low_cnt;
    logic x31, x32;
    int spurious;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel_n_8mhz", sel_n_8mhz, 1'b0);
    check("rst_sel_xclk", sel_xclk, 1'b0);
    check("rst_sel_rosc", sel_rosc, 2'b11);
    check("rst_clk_div", clk_div, 2'b00);
    check("rst_done_err", {done, err, busy}, 3'b000);
    repeat (2) @(negedge clk_mux1);
    rst_n = 1'b1;
    @(negedge clk_mux1);
    check("rst_ready", req_ready, 1'b1);

    // Request identical to reset config: done next cycle, no park toggle
    send(1'b0, 2'b11, 2'b00);
    check("same_done", done, 1'b1);
    check("same_err_busy", {err, busy}, 2'b00);
    check("same_park", sel_n_8mhz, 1'b0);
    @(negedge clk_mux1);
    check("same_done_clr", done, 1'b0);
    check("same_park2", sel_n_8mhz, 1'b0);

    // Full change to {0,01,10}
    send(1'b0, 2'b01, 2'b10);
    check("a_busy", busy, 1'b1);
    check("a_ready", req_ready, 1'b0);
    check("a_park", sel_n_8mhz, 1'b0);
    n = 0; chg = -1; low_cnt = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk_mux1);
      n++;
      if (chg < 0 && sel_rosc == 2'b01) chg = n;
      if (!sel_n_8mhz) low_cnt++;
    end
    check("a_apply_cycle", chg, 17);
    check("a_latency", n, 82);
    check("a_parked_cycles", low_cnt, 81);
    check("a_done_err", {done, err}, 2'b10);
    check("a_unpark", sel_n_8mhz, 1'b1);
    check("a_cfg", {sel_xclk, sel_rosc, clk_div}, 5'b0_01_10);
    @(negedge clk_mux1);
    check("a_done_clr", {done, busy}, 2'b00);

    // xclk requested while absent: immediate err, nothing changes
    xclk_fail = 1'b1;
    send(1'b1, 2'b01, 2'b10);
    check("c_err", {err, done}, 2'b10);
    check("c_cfg", {sel_n_8mhz, sel_xclk, sel_rosc, clk_div}, 6'b1_0_01_10);
    check("c_ready", {req_ready, busy}, 2'b10);
    @(negedge clk_mux1);
    check("c_err_clr", err, 1'b0);
    xclk_fail = 1'b0;

    // Move onto xclk
    send(1'b1, 2'b01, 2'b10);
    wait_end(200, n);
    check("d_latency", n, 82);
    check("d_done_err", {done, err}, 2'b10);
    check("d_xclk", sel_xclk, 1'b1);
    @(negedge clk_mux1);

    // xclk lost in IDLE with a simultaneous request: fallback wins
    xclk_fail    = 1'b1;
    req_sel_xclk = 1'b0;
    req_sel_rosc = 2'b00;
    req_clk_div  = 2'b01;
    req_valid    = 1'b1;
    #1;
    check("f_ready_low", req_ready, 1'b0);
    @(negedge clk_mux1);
    req_valid = 1'b0;
    check("f_busy_park", {busy, sel_n_8mhz}, 2'b10);
    wait_end(200, n);
    check("f_latency", n, 82);
    check("f_err_done", {err, done}, 2'b10);
    check("f_cfg", {sel_n_8mhz, sel_xclk, sel_rosc, clk_div}, 6'b1_0_01_10);
    @(negedge clk_mux1);
    xclk_fail = 1'b0;
    @(negedge clk_mux1);

    // xclk lost mid-SETTLE: re-apply with xclk=0, settle restarts
    send(1'b1, 2'b01, 2'b10);
    n = 0; x31 = 1'bx; x32 = 1'bx;
    while (!(done || err) && n < 300) begin
      @(negedge clk_mux1);
      n++;
      if (n == 30) xclk_fail = 1'b1;
      if (n == 31) x31 = sel_xclk;
      if (n == 32) x32 = sel_xclk;
    end
    check("s_xclk_before", x31, 1'b1);
    check("s_xclk_after", x32, 1'b0);
    check("s_latency", n, 97);
    check("s_err_done", {err, done}, 2'b10);
    check("s_cfg", {sel_n_8mhz, sel_xclk, sel_rosc, clk_div}, 6'b1_0_01_10);
    xclk_fail = 1'b0;
    @(negedge clk_mux1);

    // Reset during PARK
    send(1'b0, 2'b10, 2'b01);
    repeat (5) @(negedge clk_mux1);
    check("r_in_park", {busy, sel_n_8mhz}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("r_cfg", {sel_n_8mhz, sel_xclk, sel_rosc, clk_div}, 6'b0_0_11_00);
    check("r_flags", {busy, done, err}, 3'b000);
    @(negedge clk_mux1);
    rst_n = 1'b1;
    spurious = 0;
    repeat (100) begin
      @(negedge clk_mux1);
      if (done || err || busy) spurious++;
    end
    check("r_no_pulse", spurious, 0);
    check("r_idle", {req_ready, sel_rosc, clk_div}, 5'b1_11_00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
